// File: rtl/mem_copy_master.sv
// mem_copy_master
// Bus initiator that copies a block of 32-bit words from a source to a
// destination address. Each word costs one read access followed by one
// write access on the mem_* port set, with a mandatory one-cycle idle gap
// after every completed access.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high
//   start       in   one-cycle copy request, honoured only when idle
//   src_addr    in   first source byte address (word aligned)
//   dst_addr    in   first destination byte address (word aligned)
//   length      in   number of words to copy
//   abort       in   stop at the next word boundary
//   busy        out  copy in progress (including the done cycle)
//   done        out  one-cycle completion pulse
//   error       out  sticky failure flag, cleared by the next accepted start
//   err_addr    out  failing access address or the misaligned address
//   mem_addr    out  access address
//   mem_size    out  access size code, always WORD_SIZE_CODE
//   mem_enable  out  access request
//   mem_w_mode  out  1 = write, 0 = read
//   mem_w_data  out  write data
//   mem_r_data  in   read data, valid with mem_ready
//   mem_ready   in   access complete
//   mem_error   in   access failed, qualified by mem_ready

`ifndef MEMORY_ACCESS_SIZE
`define MEMORY_ACCESS_SIZE 1
`endif

module mem_copy_master #(
    parameter int                          LEN_W          = 16,
    parameter logic [`MEMORY_ACCESS_SIZE:0] WORD_SIZE_CODE = 2'd2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [31:0]                   src_addr,
    input  logic [31:0]                   dst_addr,
    input  logic [LEN_W-1:0]              length,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [31:0]                   err_addr,
    output logic [31:0]                   mem_addr,
    output logic [`MEMORY_ACCESS_SIZE:0]  mem_size,
    output logic                          mem_enable,
    output logic                          mem_w_mode,
    output logic [31:0]                   mem_w_data,
    input  logic [31:0]                   mem_r_data,
    input  logic                          mem_ready,
    input  logic                          mem_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [31:0]       src_r, src_s;
    logic [31:0]       dst_r, dst_s;
    logic [LEN_W-1:0]  count_r, count_s;
    logic [31:0]       data_r, data_s;
    logic              error_r, error_s;
    logic [31:0]       err_addr_r, err_addr_s;
    logic              pending_r, pending_s;
    // Distinguishes the gap after a write (word finished) from the gap after a read.
    logic              wrote_r, wrote_s;

    function automatic logic misaligned(input logic [1:0] low_bits);
        misaligned = (low_bits != 2'b00);
    endfunction

    assign error    = error_r;
    assign err_addr = err_addr_r;

    // Next-state and datapath update logic.
    always_comb begin
        state_s    = state_r;
        src_s      = src_r;
        dst_s      = dst_r;
        count_s    = count_r;
        data_s     = data_r;
        error_s    = error_r;
        err_addr_s = err_addr_r;
        wrote_s    = wrote_r;
        if ((state_r != S_IDLE) && abort) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        case (state_r)
            S_IDLE: begin
                pending_s = 1'b0;
                if (start) begin
                    error_s    = 1'b0;
                    err_addr_s = 32'h0000_0000;
                    if (misaligned(src_addr[1:0])) begin
                        error_s    = 1'b1;
                        err_addr_s = src_addr;
                        state_s    = S_DONE;
                    end else if (misaligned(dst_addr[1:0])) begin
                        error_s    = 1'b1;
                        err_addr_s = dst_addr;
                        state_s    = S_DONE;
                    end else if (length == {LEN_W{1'b0}}) begin
                        state_s = S_DONE;
                    end else begin
                        src_s   = src_addr;
                        dst_s   = dst_addr;
                        count_s = length;
                        wrote_s = 1'b0;
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    if (mem_error) begin
                        error_s    = 1'b1;
                        err_addr_s = src_r;
                    end else begin
                        data_s = mem_r_data;
                    end
                    wrote_s = 1'b0;
                    state_s = S_GAP;
                end else begin
                    state_s = S_READ;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (mem_error) begin
                        error_s    = 1'b1;
                        err_addr_s = dst_r;
                    end else begin
                        src_s   = src_r + 32'd4;
                        dst_s   = dst_r + 32'd4;
                        count_s = count_r - {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                    wrote_s = 1'b1;
                    state_s = S_GAP;
                end else begin
                    state_s = S_WRITE;
                end
            end
            S_GAP: begin
                // Abort only takes effect between words, so a word whose read
                // has completed is always written out.
                if (error_r) begin
                    state_s = S_DONE;
                end else if (!wrote_r) begin
                    state_s = S_WRITE;
                end else if (pending_r || abort || (count_r == {LEN_W{1'b0}})) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_READ;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            src_r      <= 32'h0000_0000;
            dst_r      <= 32'h0000_0000;
            count_r    <= {LEN_W{1'b0}};
            data_r     <= 32'h0000_0000;
            error_r    <= 1'b0;
            err_addr_r <= 32'h0000_0000;
            pending_r  <= 1'b0;
            wrote_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            src_r      <= src_s;
            dst_r      <= dst_s;
            count_r    <= count_s;
            data_r     <= data_s;
            error_r    <= error_s;
            err_addr_r <= err_addr_s;
            pending_r  <= pending_s;
            wrote_r    <= wrote_s;
        end
    end

    // Registered bus and status outputs, decoded from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_enable <= 1'b0;
            mem_w_mode <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_w_data <= 32'h0000_0000;
            mem_size   <= WORD_SIZE_CODE;
        end else begin
            busy       <= (state_s != S_IDLE);
            done       <= (state_s == S_DONE);
            mem_enable <= (state_s == S_READ) || (state_s == S_WRITE);
            mem_w_mode <= (state_s == S_WRITE);
            mem_addr   <= (state_s == S_READ)  ? src_s :
                          (state_s == S_WRITE) ? dst_s : 32'h0000_0000;
            mem_w_data <= (state_s == S_WRITE) ? data_s : 32'h0000_0000;
            mem_size   <= WORD_SIZE_CODE;
        end
    end

endmodule
